// File: rtl/mcu_pkg.sv
// Shared definitions for the microprogrammed MIPS control unit: uPC width,
// fixed micro-states and next-address policy encodings.
package mcu_pkg;

  localparam int STATE_W = 5;

  localparam logic [STATE_W-1:0] FETCH_STATE = 5'd0;
  localparam logic [STATE_W-1:0] TRAP_STATE  = 5'd31;

  typedef enum logic [1:0] {
    ACTL_FETCH = 2'b00,
    ACTL_DT1   = 2'b01,
    ACTL_DT2   = 2'b10,
    ACTL_SEQ   = 2'b11
  } actl_e;

  // A microword that waits on the multiply/divide unit holds while it is busy.
  function automatic logic stall_req(input logic ctl_wait, input logic mdu_busy);
    return ctl_wait & mdu_busy;
  endfunction

endpackage

// File: rtl/microsequencer_if.sv
// Microword / dispatch inputs and uPC status outputs of the microsequencer.
// master drives the microword and dispatch results, slave is the sequencer.
interface microsequencer_if #(
  parameter int STATE_W = mcu_pkg::STATE_W
);

  logic [1:0]         addr_ctl;
  logic               ctl_wait;
  logic               mdu_busy;
  logic [STATE_W-1:0] next_state_DT1;
  logic               dt1_valid;
  logic [STATE_W-1:0] next_state_DT2;
  logic               dt2_valid;

  logic [STATE_W-1:0] state;
  logic               state_entry;
  logic               illegal;
  logic [15:0]        instr_count;

  modport master (
    output addr_ctl,
    output ctl_wait,
    output mdu_busy,
    output next_state_DT1,
    output dt1_valid,
    output next_state_DT2,
    output dt2_valid,
    input  state,
    input  state_entry,
    input  illegal,
    input  instr_count
  );

  modport slave (
    input  addr_ctl,
    input  ctl_wait,
    input  mdu_busy,
    input  next_state_DT1,
    input  dt1_valid,
    input  next_state_DT2,
    input  dt2_valid,
    output state,
    output state_entry,
    output illegal,
    output instr_count
  );

endinterface

// File: rtl/useq_next_sel.sv
// Next-address mux of the microsequencer: picks the candidate micro-state from
// addr_ctl and swaps unrecognised dispatches for the trap state.
module useq_next_sel
  import mcu_pkg::*;
#(
  parameter int                 STATE_W     = mcu_pkg::STATE_W,
  parameter logic [STATE_W-1:0] FETCH_STATE = mcu_pkg::FETCH_STATE,
  parameter logic [STATE_W-1:0] TRAP_STATE  = mcu_pkg::TRAP_STATE
) (
  input  logic [STATE_W-1:0] state,
  input  logic [1:0]         addr_ctl,
  input  logic [STATE_W-1:0] next_state_DT1,
  input  logic               dt1_valid,
  input  logic [STATE_W-1:0] next_state_DT2,
  input  logic               dt2_valid,
  output logic [STATE_W-1:0] next_state,
  output logic               fetch_sel
);

  localparam logic [STATE_W-1:0] ONE = {{(STATE_W-1){1'b0}}, 1'b1};

  always_comb begin
    next_state = FETCH_STATE;
    fetch_sel  = 1'b0;
    case (actl_e'(addr_ctl))
      ACTL_FETCH: begin
        next_state = FETCH_STATE;
        fetch_sel  = 1'b1;
      end
      // Dispatch data is only trusted when the table recognised the opcode.
      ACTL_DT1: next_state = dt1_valid ? next_state_DT1 : TRAP_STATE;
      ACTL_DT2: next_state = dt2_valid ? next_state_DT2 : TRAP_STATE;
      ACTL_SEQ: next_state = state + ONE;
      default:  next_state = FETCH_STATE;
    endcase
  end

endmodule

// File: rtl/microsequencer.sv
// Microprogram sequencer: owns the uPC, holds on MDU stalls and in the trap
// state, and tracks state entry, illegal-instruction and retired-instruction status.
module microsequencer
  import mcu_pkg::*;
#(
  parameter int                 STATE_W     = mcu_pkg::STATE_W,
  parameter logic [STATE_W-1:0] FETCH_STATE = mcu_pkg::FETCH_STATE,
  parameter logic [STATE_W-1:0] TRAP_STATE  = mcu_pkg::TRAP_STATE
) (
  input  logic clk,
  input  logic reset,
  microsequencer_if.slave bus
);

  logic [STATE_W-1:0] state_q;
  logic               entry_q;
  logic               illegal_q;
  logic [15:0]        count_q;

  logic [STATE_W-1:0] sel_state;
  logic               fetch_sel;
  logic               trapped;
  logic               stalled;
  logic               hold;

  useq_next_sel #(
    .STATE_W     (STATE_W),
    .FETCH_STATE (FETCH_STATE),
    .TRAP_STATE  (TRAP_STATE)
  ) u_next_sel (
    .state          (state_q),
    .addr_ctl       (bus.addr_ctl),
    .next_state_DT1 (bus.next_state_DT1),
    .dt1_valid      (bus.dt1_valid),
    .next_state_DT2 (bus.next_state_DT2),
    .dt2_valid      (bus.dt2_valid),
    .next_state     (sel_state),
    .fetch_sel      (fetch_sel)
  );

  // The trap only leaves through reset, and takes priority over a stall.
  assign trapped = (state_q == TRAP_STATE);
  assign stalled = stall_req(bus.ctl_wait, bus.mdu_busy);
  assign hold    = trapped | stalled;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= FETCH_STATE;
      entry_q   <= 1'b1;
      illegal_q <= 1'b0;
      count_q   <= 16'd0;
    end else if (hold) begin
      entry_q <= 1'b0;
    end else begin
      state_q <= sel_state;
      entry_q <= 1'b1;
      if (sel_state == TRAP_STATE) begin
        illegal_q <= 1'b1;
      end
      if (fetch_sel) begin
        count_q <= count_q + 16'd1;
      end
    end
  end

  assign bus.state       = state_q;
  assign bus.state_entry = entry_q;
  assign bus.illegal     = illegal_q;
  assign bus.instr_count = count_q;

  a_trap_flags_illegal : assert property (
    @(posedge clk) disable iff (reset) (state_q == TRAP_STATE) |-> illegal_q
  );

endmodule

// File: tb/tb_microsequencer.sv
// Directed-vector bench for the microsequencer with a queue-based scoreboard.
module tb_microsequencer;

  typedef struct packed {
    logic [4:0]  st;
    logic        en;
    logic        il;
    logic [15:0] cnt;
  } exp_t;

  logic clk;
  logic reset;

  exp_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    errors = 0;

  microsequencer_if #(.STATE_W(5)) bus ();

  microsequencer u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string nm, input string fld, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s %s: got %0d expected %0d", nm, fld, act, req);
    end
  endtask

  // Monitor: every cycle, shortly after the edge, the oldest expectation is compared.
  initial begin
    exp_t  e;
    string n;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        cmp(n, "state",       int'(bus.state),       int'(e.st));
        cmp(n, "state_entry", int'(bus.state_entry), int'(e.en));
        cmp(n, "illegal",     int'(bus.illegal),     int'(e.il));
        cmp(n, "instr_count", int'(bus.instr_count), int'(e.cnt));
      end
    end
  end

  task automatic step(input logic rst, input logic [1:0] ac, input logic cw, input logic mb,
                      input logic [4:0] d1, input logic v1, input logic [4:0] d2, input logic v2,
                      input logic [4:0] es, input logic ee, input logic ei, input logic [15:0] ec,
                      input string nm);
    exp_t e;
    reset              = rst;
    bus.addr_ctl       = ac;
    bus.ctl_wait       = cw;
    bus.mdu_busy       = mb;
    bus.next_state_DT1 = d1;
    bus.dt1_valid      = v1;
    bus.next_state_DT2 = d2;
    bus.dt2_valid      = v2;
    e = '{st: es, en: ee, il: ei, cnt: ec};
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic rand_reset(input string nm);
    step(1'b1, 2'($urandom_range(3)), 1'($urandom_range(1)), 1'($urandom_range(1)),
         5'($urandom_range(31)), 1'($urandom_range(1)), 5'($urandom_range(31)),
         1'($urandom_range(1)), 5'd0, 1'b1, 1'b0, 16'd0, nm);
  endtask

  initial begin
    reset              = 1'b1;
    bus.addr_ctl       = 2'b00;
    bus.ctl_wait       = 1'b0;
    bus.mdu_busy       = 1'b0;
    bus.next_state_DT1 = 5'd0;
    bus.dt1_valid      = 1'b0;
    bus.next_state_DT2 = 5'd0;
    bus.dt2_valid      = 1'b0;
    @(negedge clk);

    // reset with random inputs, then sequential increments
    rand_reset("reset1");
    rand_reset("reset2");
    step(0, 2'b11, 0, 0, 5'd0, 0, 5'd0, 0, 5'd1, 1, 0, 16'd0, "seq1");
    step(0, 2'b11, 0, 0, 5'd0, 0, 5'd0, 0, 5'd2, 1, 0, 16'd0, "seq2");
    step(0, 2'b11, 0, 0, 5'd0, 0, 5'd0, 0, 5'd3, 1, 0, 16'd0, "seq3");
    step(0, 2'b00, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 1, 0, 16'd1, "fetch_a");

    // DT2 valid dispatch from state 2
    step(0, 2'b11, 0, 0, 5'd0, 0, 5'd0, 0, 5'd1, 1, 0, 16'd1, "seq_b1");
    step(0, 2'b11, 0, 0, 5'd0, 0, 5'd0, 0, 5'd2, 1, 0, 16'd1, "seq_b2");
    step(0, 2'b10, 0, 0, 5'd9, 0, 5'd24, 1, 5'd24, 1, 0, 16'd1, "dt2_valid");
    step(0, 2'b00, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 1, 0, 16'd2, "fetch_b");

    // DT2 invalid dispatch traps
    step(0, 2'b11, 0, 0, 5'd0, 0, 5'd0, 0, 5'd1, 1, 0, 16'd2, "seq_c1");
    step(0, 2'b11, 0, 0, 5'd0, 0, 5'd0, 0, 5'd2, 1, 0, 16'd2, "seq_c2");
    step(0, 2'b10, 0, 0, 5'd0, 0, 5'd24, 0, 5'd31, 1, 1, 16'd2, "dt2_invalid");

    // trap holds against fetch and valid dispatches
    for (int i = 0; i < 5; i++) begin
      step(0, 2'(i % 3), 0, 0, 5'd5, 1, 5'd24, 1, 5'd31, 0, 1, 16'd2, "trap_hold");
    end
    step(1, 2'b00, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 1, 0, 16'd0, "reset_trap");

    // MDU stall for 4 cycles, then release via fetch
    step(0, 2'b01, 0, 0, 5'd20, 1, 5'd0, 0, 5'd20, 1, 0, 16'd0, "dt1_valid");
    for (int i = 0; i < 4; i++) begin
      step(0, 2'b00, 1, 1, 5'd0, 0, 5'd0, 0, 5'd20, 0, 0, 16'd0, "stall");
    end
    step(0, 2'b00, 1, 0, 5'd0, 0, 5'd0, 0, 5'd0, 1, 0, 16'd1, "stall_release");
    step(0, 2'b00, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 1, 0, 16'd2, "fetch_selfloop");
    step(0, 2'b11, 0, 1, 5'd0, 0, 5'd0, 0, 5'd1, 1, 0, 16'd2, "busy_no_wait");
    step(0, 2'b01, 0, 0, 5'd7, 0, 5'd0, 1, 5'd31, 1, 1, 16'd2, "dt1_invalid");
    step(1, 2'b11, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 1, 0, 16'd0, "reset_c");

    // increment from 30 into the trap
    step(0, 2'b01, 0, 0, 5'd30, 1, 5'd0, 0, 5'd30, 1, 0, 16'd0, "dt1_to_30");
    step(0, 2'b11, 0, 0, 5'd0, 0, 5'd0, 0, 5'd31, 1, 1, 16'd0, "seq_into_trap");
    step(0, 2'b11, 0, 0, 5'd0, 0, 5'd0, 0, 5'd31, 0, 1, 16'd0, "seq_trap_hold");

    // reset mid-stall; a stalled fetch does not count
    step(1, 2'b00, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 1, 0, 16'd0, "reset_d");
    step(0, 2'b01, 0, 0, 5'd20, 1, 5'd0, 0, 5'd20, 1, 0, 16'd0, "dt1_20");
    step(0, 2'b00, 1, 1, 5'd0, 0, 5'd0, 0, 5'd20, 0, 0, 16'd0, "stall_d");
    step(1, 2'b00, 1, 1, 5'd0, 0, 5'd0, 0, 5'd0, 1, 0, 16'd0, "reset_in_stall");
    step(0, 2'b00, 1, 1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 16'd0, "stalled_fetch");

    // instruction count wrap: 65534 unchecked fetches, then 65535 and 0
    reset        = 1'b0;
    bus.addr_ctl = 2'b00;
    bus.ctl_wait = 1'b0;
    bus.mdu_busy = 1'b0;
    repeat (65534) @(posedge clk);
    @(negedge clk);
    step(0, 2'b00, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 1, 0, 16'hFFFF, "count_max");
    step(0, 2'b00, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 1, 0, 16'd0, "count_wrap");

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
      @(negedge clk);
    end
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/microsequencer.md
# microsequencer

Microprogram sequencer for the microprogrammed MIPS control unit. It holds the micro-program counter (uPC) and, every clock, selects the next micro-state by one of four policies:
- return to fetch;
- dispatch table 1;
- dispatch table 2;
- sequential increment.

It consumes the next-state values produced by the dispatch ROMs, stalls in multi-cycle mult/div/madd/msub states while the multiply/divide unit is busy, and traps undecodable instructions.

## Interface
Parameters:
- STATE_W, 5, width of uPC and dispatch next-state buses
- FETCH_STATE, 5'd0, first micro-state of instruction fetch; reset target
- TRAP_STATE, 5'd31, illegal-instruction micro-state

Ports:
- clk  in  1  single clock; all state changes on rising edge
- reset  in  1  synchronous, active-high reset
- addr_ctl  in  2  next-address policy from current microword: 00 fetch, 01 DT1, 10 DT2, 11 increment
- ctl_wait  in  1  microword bit: current state waits on mdu_busy
- mdu_busy  in  1  multiply/divide unit busy
- next_state_DT1  in  STATE_W  dispatch table 1 output
- dt1_valid  in  1  DT1 recognised the opcode/funct
- next_state_DT2  in  STATE_W  dispatch table 2 output
- dt2_valid  in  1  DT2 recognised the opcode/funct
- state  out  STATE_W  registered uPC; addresses the microcode ROM
- state_entry  out  1  high on the first cycle spent in the current state
- illegal  out  1  sticky; set on entry to TRAP_STATE
- instr_count  out  16  count of completed instructions (transitions into FETCH_STATE by policy 00)

## Operation
- Reset values: state=FETCH_STATE, state_entry=1, illegal=0, instr_count=0.
- Next-state priority, highest first:
  1. reset;
  2. state==TRAP_STATE: hold;
  3. stall, when ctl_wait && mdu_busy: hold;
  4. addr_ctl select.
- Policy 00: next=FETCH_STATE; instr_count increments by 1, wrapping at 16'hFFFF→0.
- Policy 01: next=next_state_DT1 if dt1_valid, else TRAP_STATE.
- Policy 10: next=next_state_DT2 if dt2_valid, else TRAP_STATE.
- Invalid-dispatch values on next_state_DTx are ignored, never forwarded; this covers unlisted funct codes on the R-type path.
- Policy 11: next=state+1, truncated to STATE_W. If the result equals TRAP_STATE, the sequencer enters the trap, which is a legal way to reach it.
- Policy 00 with FETCH_STATE already current still counts an instruction.
- The instruction count changes only on a non-stalled, non-trapped policy-00 cycle.
- illegal is set on the cycle state becomes TRAP_STATE and stays set until reset.
- state_entry:
  - registered;
  - 1 in the cycle after any non-hold transition, including a self-loop via policy 00 or 11 that lands on the same value;
  - 0 in any cycle following a stall or trap hold.
- Reset mid-stall or in trap: next cycle state=FETCH_STATE, illegal=0, count=0; mdu_busy is ignored.

## Timing
- Single-cycle sequencing: inputs sampled at edge N, new state visible after edge N.
- Combinational paths run from addr_ctl, dispatch inputs, ctl_wait and mdu_busy to the state D-input only. There are no combinational input→output paths.
- Stall release: the first cycle with mdu_busy=0 advances at that edge. There is no extra bubble.
- All outputs are registered.

## Structure
- Package mcu_pkg: STATE_W, FETCH_STATE, TRAP_STATE, and addr_ctl encodings ACTL_FETCH=2'b00, ACTL_DT1=2'b01, ACTL_DT2=2'b10, ACTL_SEQ=2'b11. The dispatch tables and microcode ROM share this package.
- One combinational sub-module, useq_next_sel, holds the addr_ctl mux plus the valid/trap substitution.
- The top level holds the uPC, stall/trap hold, state_entry, illegal and instr_count registers.

## Test plan
- Reset: assert reset 2 cycles with random inputs. Required: state=0, state_entry=1, illegal=0, instr_count=0. After release with addr_ctl=11 for 3 cycles, state goes 1,2,3.
- DT2 dispatch: state 2, addr_ctl=10, dt2_valid=1, next_state_DT2=24. Required: state=24 the next cycle, state_entry=1. Repeat with dt2_valid=0: required state=31, illegal=1.
- Stall: state 20 with ctl_wait=1, mdu_busy=1 for 4 cycles, then mdu_busy=0 with addr_ctl=00. Required: state=20 for 4 cycles with state_entry=0 after the first; then state=0 and instr_count +1.
- Trap hold: in state 31, drive addr_ctl=00 and valid dispatches for 5 cycles. Required: state=31, illegal=1, count unchanged. Then reset: state=0, illegal=0.
- Count wrap: preload by 65535 fetch transitions (or force). Required: the next policy-00 cycle gives instr_count=0.
- Increment into trap: state 30 with addr_ctl=11. Required: state=31, illegal=1.
